// File: rtl/serial_rx_sampler_if.sv
// Signal bundle between the receive controller (master) and the oversampling
// bit sampler (slave).
interface serial_rx_sampler_if;
  logic serial_rxd_data_i;
  logic serial_br_trans_i;
  logic serial_clear_count_i;
  logic serial_transition_detected_o;
  logic serial_sample_detected_o;
  logic serial_sample_valid_o;
  logic serial_shift_o;
  logic serial_start_error_o;
  logic serial_busy_o;

  modport master (
    output serial_rxd_data_i, serial_br_trans_i, serial_clear_count_i,
    input  serial_transition_detected_o, serial_sample_detected_o,
           serial_sample_valid_o, serial_shift_o, serial_start_error_o,
           serial_busy_o
  );

  modport slave (
    input  serial_rxd_data_i, serial_br_trans_i, serial_clear_count_i,
    output serial_transition_detected_o, serial_sample_detected_o,
           serial_sample_valid_o, serial_shift_o, serial_start_error_o,
           serial_busy_o
  );
endinterface

// File: rtl/serial_rx_sampler.sv
// Oversampling receive-line sampler: start-edge detection, mid-bit majority
// vote, false-start rejection and per-bit shift strobes.
module serial_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned VOTE_EN    = 1
) (
  input  logic               serial_clock_i,
  input  logic               serial_reset_i,
  serial_rx_sampler_if.slave rx_if
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_LO     = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_HI     = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_DECIDE = (VOTE_EN != 0) ? CNT_HI : CNT_MID;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             hist_q, hist_d;
  logic [1:0]       vote_q, vote_d;
  logic             sample_q, sample_d;
  logic             trans_q, trans_d;
  logic             valid_q, valid_d;
  logic             shift_q, shift_d;
  logic             err_q, err_d;
  logic             rx_s;
  logic             bit_val;

  assign rx_s    = sync_q[1];
  assign bit_val = (VOTE_EN != 0)
                 ? ((vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s))
                 : rx_s;

  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i) begin
      sync_q   <= '1;
      hist_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vote_q   <= '0;
      sample_q <= 1'b1;
      trans_q  <= 1'b0;
      valid_q  <= 1'b0;
      shift_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_if.serial_rxd_data_i};
      hist_q   <= hist_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vote_q   <= vote_d;
      sample_q <= sample_d;
      trans_q  <= trans_d;
      valid_q  <= valid_d;
      shift_q  <= shift_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vote_d   = vote_q;
    sample_d = sample_q;
    hist_d   = hist_q;
    trans_d  = 1'b0;
    valid_d  = 1'b0;
    shift_d  = 1'b0;
    err_d    = 1'b0;
    // History holds during clear so an edge masked by clear is seen next clock.
    if (rx_if.serial_clear_count_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      vote_d  = '0;
    end else begin
      hist_d = rx_s;
      if (state_q == S_IDLE) begin
        if (!rx_s && hist_q) begin
          trans_d = 1'b1;
          state_d = S_START;
        end
      end else if (rx_if.serial_br_trans_i) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (VOTE_EN != 0 && cnt_q == CNT_LO) vote_d[0] = rx_s;
        if (VOTE_EN != 0 && cnt_q == CNT_MID) vote_d[1] = rx_s;
        if (cnt_q == CNT_LAST) begin
          if (state_q == S_START) state_d = S_BIT;
          else                    shift_d = 1'b1;
        end
        // Evaluated after the wrap so a false start overrides the START->BIT move.
        if (cnt_q == CNT_DECIDE) begin
          if (state_q == S_START && bit_val) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            vote_d  = '0;
          end else begin
            sample_d = bit_val;
            valid_d  = 1'b1;
          end
        end
      end
    end
  end

  assign rx_if.serial_transition_detected_o = trans_q;
  assign rx_if.serial_sample_detected_o     = sample_q;
  assign rx_if.serial_sample_valid_o        = valid_q;
  assign rx_if.serial_shift_o               = shift_q;
  assign rx_if.serial_start_error_o         = err_q;
  assign rx_if.serial_busy_o                = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_sampler.sv
// Bench for serial_rx_sampler: directed scenarios plus random traffic, all
// checked against a frame-level reference model of the receive line.
module tb_serial_rx_sampler;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  serial_rx_sampler_if bus ();

  serial_rx_sampler #(.OVERSAMPLE(OS), .CNT_W(4), .VOTE_EN(1)) dut (
    .serial_clock_i (clk),
    .serial_reset_i (rst),
    .rx_if          (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: line delay, receiver phase within the bit, samples taken.
  bit  dl0 = 1'b1, dl1 = 1'b1, m_prev = 1'b1;
  int  m_mode = 0;   // 0 idle, 1 start bit, 2 data bits
  int  m_phase = 0;
  bit  votes[$];
  bit  m_sample = 1'b1, m_trans = 1'b0, m_valid = 1'b0, m_shift = 1'b0, m_err = 1'b0;
  logic [5:0] obs_v, exp_v;
  int  n_trans, n_valid, n_shift, n_err;
  logic last_val;

  function automatic void model_step(bit rxd, bit tick, bit clr, bit rs);
    bit s2;
    bit maj;
    bit was_start;
    int p;
    int ones;
    s2 = dl1;
    m_trans = 0; m_valid = 0; m_shift = 0; m_err = 0;
    if (rs) begin
      dl0 = 1; dl1 = 1; m_prev = 1; m_mode = 0; m_phase = 0; votes.delete(); m_sample = 1;
      return;
    end
    if (clr) begin
      m_mode = 0; m_phase = 0; votes.delete();
    end else begin
      if (m_mode == 0) begin
        if (!s2 && m_prev) begin m_trans = 1; m_mode = 1; end
      end else if (tick) begin
        p = m_phase;
        was_start = (m_mode == 1);
        m_phase = (m_phase + 1) % OS;
        if (p >= OS/2 - 1 && p <= OS/2 + 1) votes.push_back(s2);
        if (p == OS - 1) begin
          if (was_start) m_mode = 2; else m_shift = 1;
        end
        if (p == OS/2 + 1) begin
          ones = 0;
          foreach (votes[i]) ones += int'(votes[i]);
          maj = (ones * 2 > votes.size());
          votes.delete();
          if (was_start && maj) begin m_err = 1; m_mode = 0; m_phase = 0; end
          else begin m_sample = maj; m_valid = 1; end
        end
      end
      m_prev = s2;
    end
    dl1 = dl0;
    dl0 = rxd;
  endfunction

  function automatic bit tick4();
    return (cyc % 4 == 3);
  endfunction

  task automatic cycle(input bit rxd, input bit tick, input bit clr, input bit rs);
    bus.serial_rxd_data_i    = rxd;
    bus.serial_br_trans_i    = tick;
    bus.serial_clear_count_i = clr;
    rst = rs;
    @(posedge clk);
    model_step(rxd, tick, clr, rs);
    cyc++;
    #1;
    obs_v = {bus.serial_transition_detected_o, bus.serial_sample_detected_o,
             bus.serial_sample_valid_o, bus.serial_shift_o,
             bus.serial_start_error_o, bus.serial_busy_o};
    exp_v = {m_trans, m_sample, m_valid, m_shift, m_err, (m_mode != 0)};
    n_trans += int'(obs_v[5]);
    n_valid += int'(obs_v[3]);
    n_shift += int'(obs_v[2]);
    n_err   += int'(obs_v[1]);
    if (obs_v[3]) last_val = obs_v[4];
  endtask

  task automatic clear_counts();
    n_trans = 0; n_valid = 0; n_shift = 0; n_err = 0; last_val = 1'bx;
  endtask

  // Drive a start bit until the model reaches the data-bit phase.
  task automatic enter_bit(output bit ok);
    cycle(1, 0, 1, 0);
    repeat (4) cycle(1, 0, 0, 0);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      cycle(0, tick4(), 0, 0);
      ok = (m_mode == 2);
    end
  endtask

  task automatic test_reset();
    clear_counts();
    cycle(1, 0, 0, 1);
    total++; if (obs_v !== 6'b010000) begin bad++; $display("FAIL reset_first_edge got=%b want=010000", obs_v); end
    cycle(1, 0, 1, 1);
    total++; if (obs_v !== exp_v) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs_v, exp_v); end
    for (int k = 0; k < 8; k++) begin
      cycle(1, tick4(), 0, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL reset_idle k=%0d got=%b want=%b", k, obs_v, exp_v); end
    end
  endtask

  task automatic test_frame();
    int lat = 0;
    cycle(1, 0, 1, 0);
    clear_counts();
    for (int k = 0; k < 180; k++) begin
      cycle((k >= 8 && k < 72) ? 1'b0 : 1'b1, tick4(), 0, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL frame k=%0d got=%b want=%b", k, obs_v, exp_v); end
      if (obs_v[5] && lat == 0) lat = k - 7;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL frame_edge_latency got=%0d want=3", lat); end
    total++; if (n_trans !== 1) begin bad++; $display("FAIL frame_trans got=%0d want=1", n_trans); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL frame_err got=%0d want=0", n_err); end
    total++; if (n_shift !== 1) begin bad++; $display("FAIL frame_shift got=%0d want=1", n_shift); end
    total++; if (last_val !== 1'b1) begin bad++; $display("FAIL frame_bit_value got=%b want=1", last_val); end
    total++; if (obs_v[0] !== 1'b1) begin bad++; $display("FAIL frame_busy got=%b want=1", obs_v[0]); end
  endtask

  task automatic test_false_start();
    cycle(1, 0, 1, 0);
    clear_counts();
    for (int k = 0; k < 120; k++) begin
      cycle((k >= 4 && k < 20) || k >= 100 ? 1'b0 : 1'b1, tick4(), 0, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL false_start k=%0d got=%b want=%b", k, obs_v, exp_v); end
      if (k == 99) begin
        total++; if (obs_v[0] !== 1'b0) begin bad++; $display("FAIL false_start_busy got=%b want=0", obs_v[0]); end
      end
    end
    total++; if (n_err !== 1) begin bad++; $display("FAIL false_start_err got=%0d want=1", n_err); end
    total++; if (n_shift !== 0) begin bad++; $display("FAIL false_start_shift got=%0d want=0", n_shift); end
    total++; if (n_valid !== 0) begin bad++; $display("FAIL false_start_valid got=%0d want=0", n_valid); end
    total++; if (n_trans !== 2) begin bad++; $display("FAIL false_start_reaccept got=%0d want=2", n_trans); end
  endtask

  task automatic test_vote();
    bit ok;
    logic vals[$];
    bit rx = 0;
    enter_bit(ok);
    total++; if (!ok) begin bad++; $display("FAIL vote_enter got=timeout want=data_bit"); end
    for (int k = 0; k < 200 && vals.size() < 2; k++) begin
      if (cyc % 4 == 0)
        rx = (m_phase == 7) ? 1'b0 : (m_phase == 8) ? (vals.size() == 0) : 1'b1;
      cycle(rx, tick4(), 0, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL vote k=%0d got=%b want=%b", k, obs_v, exp_v); end
      if (obs_v[3]) vals.push_back(obs_v[4]);
    end
    total++; if (vals.size() !== 2) begin bad++; $display("FAIL vote_count got=%0d want=2", vals.size()); end
    else begin
      total++; if (vals[0] !== 1'b1) begin bad++; $display("FAIL vote_011 got=%b want=1", vals[0]); end
      total++; if (vals[1] !== 1'b0) begin bad++; $display("FAIL vote_001 got=%b want=0", vals[1]); end
    end
  endtask

  task automatic test_clear_wrap();
    bit ok;
    bit hit = 0;
    bit clr;
    bit t;
    enter_bit(ok);
    clear_counts();
    for (int k = 0; k < 200 && !hit; k++) begin
      t   = tick4();
      clr = t && m_mode == 2 && m_phase == OS - 1;
      cycle(1, t, clr, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL clear_wrap k=%0d got=%b want=%b", k, obs_v, exp_v); end
      hit = clr;
    end
    total++; if (!hit) begin bad++; $display("FAIL clear_wrap_reach got=timeout want=wrap_tick"); end
    total++; if (obs_v[2] !== 1'b0 || obs_v[0] !== 1'b0) begin
      bad++; $display("FAIL clear_wrap_after got=shift%b_busy%b want=shift0_busy0", obs_v[2], obs_v[0]); end
    repeat (8) cycle(1, tick4(), 0, 0);
    total++; if (n_shift !== 0) begin bad++; $display("FAIL clear_wrap_noshift got=%0d want=0", n_shift); end
  endtask

  task automatic test_clear_edge();
    int lat = -1;
    cycle(1, 0, 1, 0);
    repeat (4) cycle(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, k == 2, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL clear_edge k=%0d got=%b want=%b", k, obs_v, exp_v); end
      if (obs_v[5] && lat < 0) lat = k;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL clear_edge_recheck got=%0d want=3", lat); end
  endtask

  task automatic test_reset_mid_bit();
    bit ok;
    bit at5 = 0;
    enter_bit(ok);
    for (int k = 0; k < 200 && !at5; k++) begin
      cycle(0, tick4(), 0, 0);
      at5 = (m_mode == 2 && m_phase == 5);
    end
    total++; if (!at5) begin bad++; $display("FAIL reset_mid_reach got=timeout want=count5"); end
    cycle(0, 1, 1, 1);
    total++; if (obs_v !== 6'b010000) begin bad++; $display("FAIL reset_mid got=%b want=010000", obs_v); end
    clear_counts();
    for (int k = 0; k < 40; k++) begin
      cycle(1, tick4(), 0, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL reset_mid_after k=%0d got=%b want=%b", k, obs_v, exp_v); end
    end
    total++; if (n_trans + n_valid + n_shift + n_err !== 0) begin
      bad++; $display("FAIL reset_mid_pending got=%0d want=0", n_trans + n_valid + n_shift + n_err); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev_p = '0;
    bit rx = 1;
    cycle(1, 0, 1, 0);
    for (int k = 0; k < 320; k++) begin
      if (k == 4) rx = 0;
      else if (k > 20 && k % 16 == 4) rx = 1'($urandom_range(0, 1));
      cycle(rx, 1, k == 160, 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs_v, exp_v); end
      if ((prev_p & {obs_v[5], obs_v[3:1]}) != 0) begin
        bad++; $display("FAIL pulse_width k=%0d got=%b want=single_clock", k, obs_v);
      end
      prev_p = {obs_v[5], obs_v[3:1]};
    end
  endtask

  task automatic test_random();
    bit rx = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) rx = ~rx;
      cycle(rx, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 499) == 0);
      total++; if (obs_v !== exp_v) begin bad++; $display("FAIL random k=%0d got=%b want=%b", k, obs_v, exp_v); end
    end
  endtask

  initial begin
    bus.serial_rxd_data_i    = 1'b1;
    bus.serial_br_trans_i    = 1'b0;
    bus.serial_clear_count_i = 1'b0;
    test_reset();
    test_frame();
    test_false_start();
    test_vote();
    test_clear_wrap();
    test_clear_edge();
    test_reset_mid_bit();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_rx_sampler.md
SERIAL_RX_SAMPLER -- requirements
Module: serial_rx_sampler

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter OVERSAMPLE, default 16: baud ticks per bit, legal range 4..256.
REQ-003 Parameter CNT_W, default 4: tick counter width, at least clog2(OVERSAMPLE).
REQ-004 Parameter VOTE_EN, default 1: 1 = 3-sample majority vote, 0 = single mid-bit sample.
REQ-005 serial_clock_i  in  1  system clock; all logic on the rising edge.
REQ-006 serial_reset_i  in  1  synchronous active-high reset.
REQ-007 serial_rxd_data_i  in  1  asynchronous raw receive line, idle high.
REQ-008 serial_br_trans_i  in  1  oversample tick strobe; each clock it is high counts as one tick.
REQ-009 serial_clear_count_i  in  1  synchronous abort/end-of-frame from the controller.
REQ-010 serial_transition_detected_o  out  1  one-clock pulse on a start (falling) edge accepted in IDLE.
REQ-011 serial_sample_detected_o  out  1  last voted bit value, held between samples.
REQ-012 serial_sample_valid_o  out  1  one-clock pulse when serial_sample_detected_o updates.
REQ-013 serial_shift_o  out  1  one-clock pulse at the end of each data-bit period.
REQ-014 serial_start_error_o  out  1  one-clock pulse on a false start bit.
REQ-015 serial_busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 rxd SHALL pass through a 2-flop synchroniser (reset value 1) plus one history flop.
REQ-017 Edge detection: synchronised value 0 and history value 1 while in IDLE; the transition pulse SHALL rise on the 3rd rising edge after rxd falls, and the state SHALL move to START on that edge.
REQ-018 States: IDLE, START, BIT; the state encoding is left to the implementation.
REQ-019 Tick counter: held at 0 in IDLE; otherwise +1 on each tick, and wraps from OVERSAMPLE-1 to 0.
REQ-020 Sample points: with M = OVERSAMPLE/2, the counter values before increment are M-1, M and M+1 when VOTE_EN=1, and M only when VOTE_EN=0.
REQ-021 Vote result: majority of the three samples; the output and the valid pulse SHALL be registered on the clock after the last sample tick.
REQ-022 START: if the voted value is 1, the block SHALL pulse start_error and go to IDLE with counter 0, and SHALL NOT pulse sample_valid; if it is 0, the block SHALL stay in START.
REQ-023 START to BIT: on the wrap tick (count OVERSAMPLE-1); no shift pulse for the start bit.
REQ-024 BIT: each bit period gives exactly one sample_valid pulse (at its sample point) and one shift pulse (on the clock after its wrap tick); the block SHALL stay in BIT until clear_count_i.
REQ-025 Falling edges on rxd while in START or BIT SHALL be ignored (no transition pulse).
REQ-026 clear_count_i SHALL force state IDLE, counter 0 and vote registers 0 on the next edge; it SHALL NOT change the synchroniser or sample_detected_o.
REQ-027 clear_count_i together with a tick: clear SHALL win, and no sample, shift or error pulse SHALL be generated for that tick.
REQ-028 A falling edge and clear_count_i on the same clock in IDLE: clear SHALL win, and the edge SHALL be rechecked on the following clock.
REQ-029 All pulse outputs SHALL be high for exactly one clock, even when br_trans_i is high for several clocks.

Reset
REQ-030 With reset high, on the next edge: state IDLE, counter 0, synchroniser/history 1, sample_detected_o 1, and all pulse outputs and busy_o 0.
REQ-031 Reset SHALL override clear_count_i and any state, including mid-BIT.

Verification (OVERSAMPLE=16, VOTE_EN=1, one-clock tick every 4 clocks)
REQ-032 Reset held for 2 clocks -> sample_detected_o=1 and every other output 0 on the first edge after reset is asserted.
REQ-033 rxd 1->0 held for 16 ticks, then 1 for 16 ticks -> one transition pulse, busy=1, no start_error, sample_valid with value 1 after tick 9 of the data bit, one shift pulse after tick 15.
REQ-034 rxd low for 4 ticks and then high -> start_error pulse after sample tick 9 of START, busy=0, no shift pulse, and a new falling edge is accepted afterwards.
REQ-035 Data-bit samples at counts 7,8,9 = 0,1,1 -> sample_detected_o=1; samples 0,0,1 -> sample_detected_o=0.
REQ-036 clear_count_i on the same clock as the count-15 tick in BIT -> no shift pulse, IDLE, counter 0, busy=0 on the next clock.
REQ-037 Reset asserted mid-BIT at count 5 -> all REQ-030 reset values on the next edge, and no pending pulses afterwards.
